obs_trace_aligner: RTL and testbench
====================================

Name: obs_trace_aligner

Overview:
- Parametrised successor to the single-cycle observation source for the Sodor tiles.
- Takes NCH observation channels (PC, INSTR, WADDR, WDATA, RADDR, RDATA, ...), each a cond/arg pair.
- Delays all channels by a programmable commit latency, with squash on pipeline flush, so multi-stage cores align observations to retirement.
- Packs each non-empty cycle into a record and buffers records in a FIFO drained by a valid/ready consumer (leakage checker or trace port).

Parameters:
- NCH, 6, number of observation channels.
- AW, 32, arg width per channel; narrower sources are zero-extended by the instantiator.
- DELAY, 2, commit-alignment delay in cycles; 0 means pass-through into the FIFO stage.
- DEPTH, 8, FIFO depth in records; power of two, at least 2.
- CNTW, 16, width of the drop counter.

Ports:
- clock in 1: single clock.
- reset_n in 1: reset, asynchronous assert, active-low.
- obs_cond in NCH: per-channel observation valid; bit i is channel i.
- obs_arg in NCH*AW: channel i arg in bits [i*AW +: AW].
- flush in 1: squash all in-flight delay-line entries.
- out_valid out 1: FIFO head holds a record.
- out_ready in 1: consumer accepts the head.
- out_mask out NCH: head record cond mask.
- out_args out NCH*AW: head record args; a channel whose mask bit is 0 reads 0.
- overflow out 1: sticky flag, set when a record was dropped.
- drop_cnt out CNTW: number of dropped records, saturating.
- clr_stats in 1: clears overflow and drop_cnt.

Behaviour:
- Reset values: out_valid=0, out_mask=0, out_args=0, overflow=0, drop_cnt=0. All delay-line valid bits and FIFO pointers are 0.
- Delay line: DELAY stages, each holding {mask, args}.
  - A stage's args register loads only when its mask is nonzero.
  - Stage 0 captures obs_cond and obs_arg masked per channel (arg zeroed where cond=0).
  - With DELAY=0 the inputs feed the enqueue logic combinationally.
- flush: clears the mask of every delay stage in the same edge. The input sampled in the flush cycle is also dropped. Entries already in the FIFO are unaffected.
- Enqueue: happens when the delay-line output mask is nonzero and the FIFO is not full, or the FIFO is full and a dequeue fires in the same cycle (simultaneous enq and deq at full is allowed).
- Dropped record: the delay-line output mask is nonzero and the FIFO is full with no dequeue.
  - overflow is set to 1.
  - drop_cnt increments and saturates at 2^CNTW-1.
- Dequeue: out_valid && out_ready.
  - out_valid is registered and reflects occupancy > 0.
  - Head outputs are driven from the FIFO storage at the read pointer.
- Total latency: an observation at cycle t appears at the FIFO head at cycle t+DELAY+1 when the FIFO was empty.
- Pointers are log2(DEPTH)+1 bits and wrap naturally. full = MSBs differ and LSBs are equal.
- clr_stats has priority over a simultaneous drop in the same cycle: result is overflow=0, drop_cnt=0.
- Asserting reset_n low mid-stream discards the delay line and the FIFO contents immediately.

Optional Feature:
- Macro OBS_TRACE_CYCLE_STAMP_EN.
- When defined:
  - Adds a free-running 32-bit cycle counter, reset to 0, that increments every cycle and wraps.
  - Adds output out_stamp (32 bits), the counter value at the cycle the record entered stage 0.
  - The stamp travels through the delay line and the FIFO with the record.
- When undefined: no counter, no out_stamp port, no stamp storage.

Decomposition:
- Package obs_trace_pkg holds:
  - Channel index constants: CH_PC=0, CH_INSTR=1, CH_WADDR=2, CH_WDATA=3, CH_RADDR=4, CH_RDATA=5.
  - A record struct typedef parametrised by NCH and AW via localparams.
  - The saturating-increment function.
- One sub-module is natural: obs_trace_fifo (storage, pointers, full/empty, registered valid). The delay line and drop statistics stay in the top.

Test Plan:
- DELAY=2, DEPTH=8, out_ready=1. Drive obs_cond=6'b000011 with PC arg 0x80000000 at t=0 -> at t=3 out_valid=1, out_mask=000011, PC field=0x80000000, other fields 0.
- obs_cond=6'b010000 at t=0, flush=1 at t=1 -> no record ever appears; drop_cnt stays 0.
- out_ready=0, 10 consecutive nonzero records -> 8 records stored, overflow=1, drop_cnt=2. Then drain with out_ready=1 -> 8 records in input order.
- FIFO full, new record arrives with out_ready=1 in the same cycle -> no drop, occupancy stays 8, drop_cnt unchanged.
- drop_cnt at 0xFFFF plus another drop -> stays 0xFFFF. Pulse clr_stats together with a drop -> drop_cnt=0, overflow=0.
- With OBS_TRACE_CYCLE_STAMP_EN, DELAY=2, reset released at cycle 0, record injected at cycle 5 -> out_stamp=5 at the head at cycle 8.

Source files
------------

// File: rtl/obs_trace_pkg.sv
// obs_trace_pkg: shared channel indices, default record layout and the
// saturating counter helper for the observation trace aligner.
package obs_trace_pkg;

  localparam int CH_PC    = 0;
  localparam int CH_INSTR = 1;
  localparam int CH_WADDR = 2;
  localparam int CH_WDATA = 3;
  localparam int CH_RADDR = 4;
  localparam int CH_RDATA = 5;

  localparam int REC_NCH = 6;
  localparam int REC_AW  = 32;

  typedef struct packed {
    logic [REC_NCH-1:0]        mask;
    logic [REC_NCH*REC_AW-1:0] args;
  } obs_rec_t;

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input int          w
  );
    logic [31:0] top;
    top = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= top) ? top : v + 32'd1;
  endfunction

endpackage

// File: rtl/obs_trace_fifo.sv
// obs_trace_fifo: record FIFO with wrap-bit pointers and registered valid.
// Ports: in_valid/in_ready/in_data enqueue, out_valid/out_ready/out_data head.
module obs_trace_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  localparam int IW   = $clog2(DEPTH);
  localparam int PTRW = IW + 1;

  logic [W-1:0]    mem [DEPTH];
  logic [PTRW-1:0] wptr, rptr;
  logic [PTRW-1:0] wptr_n, rptr_n;
  logic            full, enq, deq;

  assign full = (wptr[IW] != rptr[IW]) &&
                (wptr[IW-1:0] == rptr[IW-1:0]);
  assign deq      = out_valid && out_ready;
  // A slot frees up in the same edge, so full+deq may enqueue.
  assign in_ready = !full || deq;
  assign enq      = in_valid && in_ready;
  assign wptr_n   = wptr + PTRW'(enq);
  assign rptr_n   = rptr + PTRW'(deq);
  assign out_data = mem[rptr[IW-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr      <= '0;
      rptr      <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      wptr      <= wptr_n;
      rptr      <= rptr_n;
      out_valid <= (wptr_n != rptr_n);
      if (enq)
        mem[wptr[IW-1:0]] <= in_data;
    end
  end

endmodule

// File: rtl/obs_trace_aligner.sv
// obs_trace_aligner: delays NCH cond/arg observation channels by DELAY
// cycles (squashed by flush), queues non-empty cycles as records in a FIFO.
// Ports: obs_cond/obs_arg in, flush, out_valid/out_ready/out_mask/out_args,
// overflow/drop_cnt/clr_stats; out_stamp under OBS_TRACE_CYCLE_STAMP_EN.
module obs_trace_aligner
  import obs_trace_pkg::*;
#(
  parameter int NCH   = 6,
  parameter int AW    = 32,
  parameter int DELAY = 2,
  parameter int DEPTH = 8,
  parameter int CNTW  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NCH-1:0]    obs_cond,
  input  logic [NCH*AW-1:0] obs_arg,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NCH-1:0]    out_mask,
  output logic [NCH*AW-1:0] out_args,
  output logic              overflow,
  output logic [CNTW-1:0]   drop_cnt,
  input  logic              clr_stats
`ifdef OBS_TRACE_CYCLE_STAMP_EN
  ,
  output logic [31:0]       out_stamp
`endif
);

`ifdef OBS_TRACE_CYCLE_STAMP_EN
  localparam int SW = 32;
`else
  localparam int SW = 0;
`endif
  localparam int PW = NCH * AW;
  localparam int RW = NCH + PW + SW;

  logic [PW-1:0]  in_args;
  logic [NCH-1:0] dl_mask;
  logic [PW-1:0]  dl_args;
  logic [RW-1:0]  fifo_in, fifo_out;
  logic           enq_req, fifo_ready, drop;

  always_comb begin
    in_args = '0;
    for (int i = 0; i < NCH; i++)
      in_args[i*AW +: AW] = obs_cond[i] ? obs_arg[i*AW +: AW] : '0;
  end

`ifdef OBS_TRACE_CYCLE_STAMP_EN
  logic [31:0] cyc_q;
  logic [31:0] dl_stamp;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      cyc_q <= '0;
    else
      cyc_q <= cyc_q + 32'd1;
  end
`endif

  if (DELAY == 0) begin : g_pass
    // The input of a flush cycle is squashed even with no delay stages.
    assign dl_mask = flush ? '0 : obs_cond;
    assign dl_args = in_args;
`ifdef OBS_TRACE_CYCLE_STAMP_EN
    assign dl_stamp = cyc_q;
`endif
  end else begin : g_line
    logic [NCH-1:0] m_q [DELAY];
    logic [PW-1:0]  a_q [DELAY];
`ifdef OBS_TRACE_CYCLE_STAMP_EN
    logic [31:0]    s_q [DELAY];
`endif

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        for (int k = 0; k < DELAY; k++) begin
          m_q[k] <= '0;
          a_q[k] <= '0;
`ifdef OBS_TRACE_CYCLE_STAMP_EN
          s_q[k] <= '0;
`endif
        end
      end else begin
        m_q[0] <= flush ? '0 : obs_cond;
        if (|obs_cond) begin
          a_q[0] <= in_args;
`ifdef OBS_TRACE_CYCLE_STAMP_EN
          s_q[0] <= cyc_q;
`endif
        end
        for (int k = 1; k < DELAY; k++) begin
          m_q[k] <= flush ? '0 : m_q[k-1];
          if (|m_q[k-1]) begin
            a_q[k] <= a_q[k-1];
`ifdef OBS_TRACE_CYCLE_STAMP_EN
            s_q[k] <= s_q[k-1];
`endif
          end
        end
      end
    end

    assign dl_mask = m_q[DELAY-1];
    assign dl_args = a_q[DELAY-1];
`ifdef OBS_TRACE_CYCLE_STAMP_EN
    assign dl_stamp = s_q[DELAY-1];
`endif
  end

`ifdef OBS_TRACE_CYCLE_STAMP_EN
  assign fifo_in = {dl_mask, dl_args, dl_stamp};
  assign {out_mask, out_args, out_stamp} = fifo_out;
`else
  assign fifo_in = {dl_mask, dl_args};
  assign {out_mask, out_args} = fifo_out;
`endif

  assign enq_req = |dl_mask;
  assign drop    = enq_req && !fifo_ready;

  obs_trace_fifo #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (enq_req),
    .in_ready  (fifo_ready),
    .in_data   (fifo_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (fifo_out)
  );

  // A clear wins over a drop landing in the same cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_stats) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      drop_cnt <= CNTW'(sat_inc(32'(drop_cnt), CNTW));
    end
  end

endmodule

// File: tb/tb_obs_trace_aligner.sv
// tb_obs_trace_aligner: scoreboard bench for obs_trace_aligner with a
// queue-based reference model, directed cases and randomized traffic.
module tb_obs_trace_aligner;
  import obs_trace_pkg::*;

  localparam int NCH   = REC_NCH;
  localparam int AW    = REC_AW;
  localparam int DELAY = 2;
  localparam int DEPTH = 8;
  localparam int CNTW  = 16;
  localparam int MAXC  = (1 << CNTW) - 1;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [NCH-1:0]    obs_cond = '0;
  logic [NCH*AW-1:0] obs_arg = '0;
  logic              flush = 1'b0;
  logic              out_ready = 1'b0;
  logic              clr_stats = 1'b0;
  logic              out_valid;
  logic [NCH-1:0]    out_mask;
  logic [NCH*AW-1:0] out_args;
  logic              overflow;
  logic [CNTW-1:0]   drop_cnt;
`ifdef OBS_TRACE_CYCLE_STAMP_EN
  logic [31:0]       out_stamp;
`endif

  obs_trace_aligner #(
    .NCH(NCH), .AW(AW), .DELAY(DELAY), .DEPTH(DEPTH), .CNTW(CNTW)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .obs_cond  (obs_cond),
    .obs_arg   (obs_arg),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mask  (out_mask),
    .out_args  (out_args),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .clr_stats (clr_stats)
`ifdef OBS_TRACE_CYCLE_STAMP_EN
    ,
    .out_stamp (out_stamp)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    obs_rec_t    r;
    int unsigned st;
  } rec_t;

  typedef struct {
    int unsigned due;
    rec_t        e;
  } pend_t;

  pend_t       pend[$];
  rec_t        exp_q[$];
  int          model_occ = 0;
  int          m_occ_now = 0;
  int          m_cnt = 0;
  int          m_cnt_now = 0;
  logic        m_ov = 1'b0;
  logic        m_ov_now = 1'b0;
  int unsigned cyc = 0;
  int          pops = 0;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [NCH*AW-1:0] zero_off(
    input logic [NCH-1:0]    c,
    input logic [NCH*AW-1:0] a
  );
    logic [NCH*AW-1:0] r;
    r = a;
    for (int i = 0; i < NCH; i++)
      if (!c[i]) r[i*AW +: AW] = '0;
    return r;
  endfunction

  function automatic logic [NCH*AW-1:0] rnd_args();
    logic [NCH*AW-1:0] r;
    for (int i = 0; i < NCH; i++)
      r[i*AW +: AW] = $urandom;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference: a record sampled at cycle t reaches the FIFO at t+DELAY
  // unless a flush occurs in cycles t..t+DELAY-1.
  task automatic model_cycle(input logic [NCH-1:0] c,
                             input logic [NCH*AW-1:0] a,
                             input logic fl, input logic rd,
                             input logic clr);
    pend_t keep[$];
    pend_t p;
    rec_t  e;
    logic  has_arr, deq, drp;
    m_occ_now = model_occ;
    m_ov_now  = m_ov;
    m_cnt_now = m_cnt;
    if (fl) begin
      foreach (pend[i])
        if (pend[i].due <= cyc) keep.push_back(pend[i]);
      pend = keep;
    end
    if (!fl && c != '0) begin
      e.r.mask = c;
      e.r.args = zero_off(c, a);
      e.st     = cyc;
      p.due    = cyc + DELAY;
      p.e      = e;
      pend.push_back(p);
    end
    has_arr = 1'b0;
    drp     = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      p = pend.pop_front();
      has_arr = 1'b1;
    end
    deq = (model_occ > 0) && rd;
    if (has_arr) begin
      if (model_occ < DEPTH || deq) begin
        exp_q.push_back(p.e);
        model_occ++;
      end else begin
        drp = 1'b1;
      end
    end
    if (deq) model_occ--;
    if (clr) begin
      m_ov  = 1'b0;
      m_cnt = 0;
    end else if (drp) begin
      m_ov = 1'b1;
      if (m_cnt < MAXC) m_cnt++;
    end
    cyc++;
  endtask

  task automatic step(input logic [NCH-1:0] c,
                      input logic [NCH*AW-1:0] a,
                      input logic fl, input logic rd,
                      input logic clr);
    @(posedge clock);
    #1;
    obs_cond  = c;
    obs_arg   = a;
    flush     = fl;
    out_ready = rd;
    clr_stats = clr;
    model_cycle(c, a, fl, rd, clr);
  endtask

  task automatic idle(input logic rd);
    step('0, rnd_args(), 1'b0, rd, 1'b0);
  endtask

  task automatic rec(input logic rd);
    step(NCH'($urandom_range(1, (1 << NCH) - 1)), rnd_args(),
         1'b0, rd, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset_n   = 1'b0;
    obs_cond  = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    clr_stats = 1'b0;
    pend.delete();
    exp_q.delete();
    model_occ = 0;
    m_occ_now = 0;
    m_cnt = 0;
    m_cnt_now = 0;
    m_ov = 1'b0;
    m_ov_now = 1'b0;
    @(negedge clock);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_mask", 64'(out_mask), 64'd0);
    chk("rst_out_args", 64'(|out_args), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    @(posedge clock);
    @(negedge clock);
    #1;
    reset_n = 1'b1;
    cyc = 1;
  endtask

  // Monitor: compares every cycle and pops on each accepted head record.
  always @(negedge clock) begin
    rec_t e;
    checks++;
    if (out_valid !== (m_occ_now > 0)) begin
      errors++;
      $display("FAIL out_valid: got %0b expected %0b",
               out_valid, (m_occ_now > 0));
    end
    checks++;
    if (overflow !== m_ov_now) begin
      errors++;
      $display("FAIL overflow: got %0b expected %0b", overflow, m_ov_now);
    end
    checks++;
    if (drop_cnt !== CNTW'(m_cnt_now)) begin
      errors++;
      $display("FAIL drop_cnt: got %0h expected %0h",
               drop_cnt, CNTW'(m_cnt_now));
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL head_unexpected: got mask %0h expected none",
                 out_mask);
      end else begin
        e = exp_q.pop_front();
        pops++;
        if (out_mask !== e.r.mask || out_args !== e.r.args) begin
          errors++;
          $display("FAIL head_record: got %0h/%0h expected %0h/%0h",
                   out_mask, out_args, e.r.mask, e.r.args);
        end
`ifdef OBS_TRACE_CYCLE_STAMP_EN
        checks++;
        if (out_stamp !== e.st) begin
          errors++;
          $display("FAIL head_stamp: got %0d expected %0d",
                   out_stamp, e.st);
        end
`endif
      end
    end
  end

  initial begin
    logic [NCH*AW-1:0] a;
    int p0;

    do_reset();

    // First record: PC/INSTR valid, RADDR arg present but not valid.
    a = '0;
    a[CH_PC*AW +: AW]    = 32'h8000_0000;
    a[CH_INSTR*AW +: AW] = 32'h0000_0513;
    a[CH_RADDR*AW +: AW] = 32'hdead_beef;
    step(6'b000011, a, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    chk("lat_t2_valid", 64'(out_valid), 64'd0);
    idle(1'b1);
    chk("lat_t3_valid", 64'(out_valid), 64'd1);
    chk("lat_t3_mask", 64'(out_mask), 64'h3);
    chk("lat_t3_pc", 64'(out_args[CH_PC*AW +: AW]), 64'h8000_0000);
    chk("lat_t3_instr", 64'(out_args[CH_INSTR*AW +: AW]), 64'h513);
    chk("lat_t3_others", 64'(|out_args[NCH*AW-1:2*AW]), 64'd0);

    // Flush squashes a record still in the delay line.
    step(6'b010000, rnd_args(), 1'b0, 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b1, 1'b0);
    repeat (4) begin
      idle(1'b1);
      chk("flush_no_rec", 64'(out_valid), 64'd0);
    end
    chk("flush_drop_cnt", 64'(drop_cnt), 64'd0);

    // Ten records into a stalled FIFO: eight kept, two dropped.
    repeat (10) rec(1'b0);
    repeat (3) idle(1'b0);
    chk("ovf_flag", 64'(overflow), 64'd1);
    chk("ovf_drop_cnt", 64'(drop_cnt), 64'd2);
    p0 = pops;
    repeat (10) idle(1'b1);
    chk("ovf_drain_cnt", 64'(pops - p0), 64'd8);
    chk("ovf_drained", 64'(out_valid), 64'd0);

    // Enqueue at full with a same-cycle dequeue is not a drop.
    step('0, '0, 1'b0, 1'b1, 1'b1);
    repeat (8) rec(1'b0);
    repeat (2) idle(1'b0);
    rec(1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);
    chk("full_deq_drop", 64'(drop_cnt), 64'd0);
    chk("full_deq_ovf", 64'(overflow), 64'd0);
    rec(1'b0);
    repeat (3) idle(1'b0);
    chk("still_full", 64'(drop_cnt), 64'd1);
    p0 = pops;
    repeat (10) idle(1'b1);
    chk("full_occ8", 64'(pops - p0), 64'd8);

    // Saturation of drop_cnt, then clear racing a drop.
    step('0, '0, 1'b0, 1'b1, 1'b1);
    a = rnd_args();
    repeat (DEPTH + DELAY + MAXC + 5)
      step(6'b100001, a, 1'b0, 1'b0, 1'b0);
    chk("sat_drop_cnt", 64'(drop_cnt), 64'(MAXC));
    chk("sat_ovf", 64'(overflow), 64'd1);
    step(6'b100001, a, 1'b0, 1'b0, 1'b1);
    step(6'b100001, a, 1'b0, 1'b0, 1'b0);
    chk("clr_wins_cnt", 64'(drop_cnt), 64'd0);
    chk("clr_wins_ovf", 64'(overflow), 64'd0);
    idle(1'b0);
    chk("post_clr_cnt", 64'(drop_cnt), 64'd1);
    repeat (12) idle(1'b1);

    // Randomized traffic, then a reset mid-stream.
    repeat (1200) begin
      step(($urandom_range(0, 9) < 3) ? '0 : NCH'($urandom_range(0, 63)),
           rnd_args(), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 49) == 0));
    end
    do_reset();

`ifdef OBS_TRACE_CYCLE_STAMP_EN
    while (cyc < 5) idle(1'b1);
    rec(1'b1);
    repeat (3) idle(1'b1);
    chk("stamp_valid", 64'(out_valid), 64'd1);
    chk("stamp_value", 64'(out_stamp), 64'd5);
`endif

    repeat (1200) begin
      step(($urandom_range(0, 9) < 3) ? '0 : NCH'($urandom_range(0, 63)),
           rnd_args(), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 49) == 0));
    end

    for (int i = 0; i < 40; i++) begin
      if (model_occ == 0 && pend.size() == 0) break;
      idle(1'b1);
    end
    idle(1'b1);
    chk("final_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
